// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed 7-segment scan controller: segment
// encodings, the hex font and the counter-width helper.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // gfedcba, active-low, indexed by hex nibble
    localparam logic [6:0] FONT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic int count_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg7_font_rom.sv
// Combinational hex nibble to active-low gfedcba segment pattern.
module seg7_font_rom
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = FONT[nibble];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode 7-segment scanner with frame-synchronous loading,
// leading-zero blanking, per-slot guard blanking and PWM dimming.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int TICK_CYCLES  = 100000,
    parameter int BLANK_CYCLES = 2000,
    parameter int DIM_BITS     = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    lz_blank,
    input  logic [DIM_BITS-1:0]     brightness,
    input  logic                    load,
    output logic [6:0]              g_to_a,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    dp,
    output logic                    frame_start
);

    localparam int IDX_W = count_width(NUM_DIGITS);
    localparam int CNT_W = count_width(TICK_CYCLES);
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(TICK_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_END = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        slot_q, slot_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DIM_BITS-1:0]     pwm_q, pwm_d;

    logic [4*NUM_DIGITS-1:0] act_value_q, act_value_d;
    logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0]   act_en_q, act_en_d;
    logic                    act_lz_q, act_lz_d;
    logic [4*NUM_DIGITS-1:0] pend_value_q, pend_value_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic [NUM_DIGITS-1:0]   pend_en_q, pend_en_d;
    logic                    pend_lz_q, pend_lz_d;
    logic                    pend_flag_q, pend_flag_d;

    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    dp_q, dp_d;
    logic                    frame_start_q, frame_start_d;

    logic                    slot_wrap, frame_end;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic [3:0]              cur_nib;
    logic                    cur_dp, cur_en, cur_blank, lit;
    logic [6:0]              font_seg;

    always_comb begin
        slot_wrap = (slot_q == SLOT_LAST);
        frame_end = slot_wrap && (idx_q == IDX_LAST);
        slot_d    = slot_wrap ? '0 : slot_q + 1'b1;
        idx_d     = idx_q;
        if (slot_wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        pwm_d = pwm_q + 1'b1;
    end

    // Pending registers absorb loads; the active set only changes at the frame
    // boundary, where a same-cycle load takes priority over older pending data.
    always_comb begin
        pend_value_d = pend_value_q;
        pend_dp_d    = pend_dp_q;
        pend_en_d    = pend_en_q;
        pend_lz_d    = pend_lz_q;
        pend_flag_d  = pend_flag_q;
        act_value_d  = act_value_q;
        act_dp_d     = act_dp_q;
        act_en_d     = act_en_q;
        act_lz_d     = act_lz_q;
        if (load) begin
            pend_value_d = value;
            pend_dp_d    = dp_in;
            pend_en_d    = digit_en;
            pend_lz_d    = lz_blank;
            pend_flag_d  = 1'b1;
        end
        if (frame_end) begin
            pend_flag_d = 1'b0;
            if (load) begin
                act_value_d = value;
                act_dp_d    = dp_in;
                act_en_d    = digit_en;
                act_lz_d    = lz_blank;
            end else if (pend_flag_q) begin
                act_value_d = pend_value_q;
                act_dp_d    = pend_dp_q;
                act_en_d    = pend_en_q;
                act_lz_d    = pend_lz_q;
            end
        end
    end

    always_comb begin
        logic upper_nz;
        upper_nz = 1'b0;
        lz_mask  = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (act_value_q[4*i +: 4] != 4'h0) begin
                upper_nz = 1'b1;
            end
            lz_mask[i] = act_lz_q && !upper_nz;
        end
    end

    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_en    = 1'b0;
        cur_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib   = act_value_q[4*i +: 4];
                cur_dp    = act_dp_q[i];
                cur_en    = act_en_q[i];
                cur_blank = lz_mask[i];
            end
        end
    end

    seg7_font_rom u_font (
        .nibble (cur_nib),
        .seg    (font_seg)
    );

    // Segments follow the index at all times; the guard window hides the change.
    always_comb begin
        seg_d         = (cur_en && !cur_blank) ? font_seg : SEG_OFF;
        dp_d          = !(cur_en && cur_dp);
        lit           = (slot_q >= GUARD_END) && cur_en && (pwm_q <= brightness);
        frame_start_d = (slot_q == '0) && (idx_q == '0);
        an_d          = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (lit && (idx_q == IDX_W'(i))) begin
                an_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q        <= '0;
            idx_q         <= '0;
            pwm_q         <= '0;
            act_value_q   <= '0;
            act_dp_q      <= '0;
            act_en_q      <= '0;
            act_lz_q      <= 1'b0;
            pend_value_q  <= '0;
            pend_dp_q     <= '0;
            pend_en_q     <= '0;
            pend_lz_q     <= 1'b0;
            pend_flag_q   <= 1'b0;
            seg_q         <= SEG_OFF;
            an_q          <= '1;
            dp_q          <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            slot_q        <= slot_d;
            idx_q         <= idx_d;
            pwm_q         <= pwm_d;
            act_value_q   <= act_value_d;
            act_dp_q      <= act_dp_d;
            act_en_q      <= act_en_d;
            act_lz_q      <= act_lz_d;
            pend_value_q  <= pend_value_d;
            pend_dp_q     <= pend_dp_d;
            pend_en_q     <= pend_en_d;
            pend_lz_q     <= pend_lz_d;
            pend_flag_q   <= pend_flag_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
            dp_q          <= dp_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign g_to_a      = seg_q;
    assign an          = an_q;
    assign dp          = dp_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a cycle-time reference model predicts
// every registered output; a separate monitor pops and compares each cycle.
module tb_seg7_scan_ctrl;

    localparam int N     = 4;
    localparam int T     = 8;
    localparam int B     = 2;
    localparam int D     = 2;
    localparam int FRAME = N * T;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fs;
    } out_t;

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dpv;
        logic [3:0]  en;
        logic        lz;
    } regs_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic        lz_blank;
    logic [1:0]  brightness;
    logic        load;
    logic [6:0]  g_to_a;
    logic [3:0]  an;
    logic        dp;
    logic        frame_start;

    seg7_scan_ctrl #(
        .NUM_DIGITS   (N),
        .TICK_CYCLES  (T),
        .BLANK_CYCLES (B),
        .DIM_BITS     (D)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .value       (value),
        .dp_in       (dp_in),
        .digit_en    (digit_en),
        .lz_blank    (lz_blank),
        .brightness  (brightness),
        .load        (load),
        .g_to_a      (g_to_a),
        .an          (an),
        .dp          (dp),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    logic [6:0] font_ref [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    out_t  exp_q[$];
    regs_t m_act;
    regs_t m_pend;
    bit    m_flag;
    int    t;
    int    n_compared = 0;
    int    n_mismatch = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_compared++;
        if (act !== req) begin
            n_mismatch++;
            $display("[TB] FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Expected registered outputs after the edge that ends elapsed cycle tc
    function automatic out_t model_out(input int tc, input regs_t a, input logic [1:0] br);
        out_t        o;
        int          slot;
        int          idx;
        int          pwm;
        logic [15:0] upper;
        logic        en;
        logic        blank;
        slot  = tc % T;
        idx   = (tc / T) % N;
        pwm   = tc % (1 << D);
        upper = a.value >> (4 * idx);
        en    = a.en[idx];
        blank = a.lz && (idx > 0) && (upper == 16'h0);
        o.seg = (en && !blank) ? font_ref[upper[3:0]] : 7'h7F;
        o.dp  = !(en && a.dpv[idx]);
        o.an  = 4'hF;
        if (slot >= B && en && pwm <= int'(br)) o.an[idx] = 1'b0;
        o.fs  = (slot == 0) && (idx == 0);
        return o;
    endfunction

    task automatic modelReset();
        m_act  = '0;
        m_pend = '0;
        m_flag = 1'b0;
        t      = 0;
    endtask

    // Drives one cycle of inputs (called at a falling edge) and records the prediction
    task automatic applyStimulus(input bit ld, input logic [15:0] v, input logic [3:0] dpi,
                                 input logic [3:0] en, input bit lz, input logic [1:0] br);
        regs_t in;
        load       = ld;
        value      = v;
        dp_in      = dpi;
        digit_en   = en;
        lz_blank   = lz;
        brightness = br;
        exp_q.push_back(model_out(t, m_act, br));
        in = '{value: v, dpv: dpi, en: en, lz: lz};
        if ((t % FRAME) == FRAME - 1) begin
            if (ld) m_act = in;
            else if (m_flag) m_act = m_pend;
            m_flag = 1'b0;
        end else if (ld) begin
            m_pend = in;
            m_flag = 1'b1;
        end
        t++;
        @(negedge clk);
    endtask

    task automatic idle(input int cycles, input logic [1:0] br);
        for (int i = 0; i < cycles; i++) begin
            applyStimulus(1'b0, 16'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), br);
        end
    endtask

    task automatic runToPhase(input int phase, input logic [1:0] br);
        while ((t % FRAME) != phase) idle(1, br);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " an"}, 32'(an), 32'hF);
        checkOutput({tag, " g_to_a"}, 32'(g_to_a), 32'h7F);
        checkOutput({tag, " dp"}, 32'(dp), 32'h1);
        checkOutput({tag, " frame_start"}, 32'(frame_start), 32'h0);
    endtask

    task automatic drainQueue();
        for (int i = 0; i < 4 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #3;
        end
        checkOutput("queue drained", 32'(exp_q.size()), 32'h0);
    endtask

    initial begin : monitor
        out_t e;
        out_t a;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = '{an: an, seg: g_to_a, dp: dp, fs: frame_start};
                checkOutput($sformatf("scan@%0t {an,seg,dp,fs}", $time), 32'(a), 32'(e));
            end
        end
    end

    initial begin : stimulus
        rst_n      = 1'b0;
        load       = 1'b0;
        value      = '0;
        dp_in      = '0;
        digit_en   = '0;
        lz_blank   = 1'b0;
        brightness = '0;
        modelReset();
        repeat (5) @(negedge clk);
        checkResetOutputs("reset");
        rst_n = 1'b1;
        $display("[TB] reset released");

        idle(2 * FRAME, 2'd3);

        runToPhase(10, 2'd3);
        applyStimulus(1'b1, 16'hA3F0, 4'b0100, 4'hF, 1'b0, 2'd3);
        idle(3 * FRAME, 2'd3);

        runToPhase(5, 2'd3);
        applyStimulus(1'b1, 16'h1111, 4'h0, 4'hF, 1'b0, 2'd3);
        runToPhase(20, 2'd3);
        applyStimulus(1'b1, 16'h2222, 4'h0, 4'hF, 1'b0, 2'd3);
        idle(3 * FRAME, 2'd3);

        runToPhase(FRAME - 1, 2'd3);
        applyStimulus(1'b1, 16'h5678, 4'b1001, 4'hF, 1'b0, 2'd3);
        idle(2 * FRAME, 2'd3);

        applyStimulus(1'b1, 16'h0050, 4'h0, 4'hF, 1'b1, 2'd3);
        idle(2 * FRAME, 2'd3);
        applyStimulus(1'b1, 16'h0000, 4'h0, 4'hF, 1'b1, 2'd3);
        idle(2 * FRAME, 2'd3);

        applyStimulus(1'b1, 16'h9C4E, 4'hF, 4'b1010, 1'b0, 2'd1);
        idle(3 * FRAME, 2'd1);

        $display("[TB] random phase");
        for (int i = 0; i < 20 * FRAME; i++) begin
            applyStimulus(($urandom_range(0, 15) == 0), 16'($urandom), 4'($urandom),
                          4'($urandom), 1'($urandom), 2'($urandom));
        end

        drainQueue();
        #2;
        rst_n = 1'b0;
        #1;
        checkResetOutputs("async reset");
        @(negedge clk);
        @(negedge clk);
        modelReset();
        rst_n = 1'b1;
        idle(FRAME, 2'd3);
        applyStimulus(1'b1, 16'hBEEF, 4'b0010, 4'hF, 1'b0, 2'd3);
        idle(3 * FRAME, 2'd2);

        drainQueue();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
